// File: rtl/memory_arbiter_pkg.sv
// Shared package for the memory arbiter and the pipeline stages around it.
// Holds the default bus widths, the default ack timeout and the arbiter
// state encoding.
package memory_arbiter_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefTimeout   = 255;

  // IDLE: no RAM transaction outstanding.
  // FETCH / DATA: one transaction outstanding for the fetch or memory stage.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StData  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/memory_arbiter_ack_watchdog.sv
// Ack watchdog: counts the cycles an outstanding RAM transaction has waited
// for ram_ack and flags expiry once TIMEOUT cycles have passed without one.
//
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clear   - restart the count (no transaction, or ack this cycle)
//   enable  - count this cycle (transaction outstanding, no ack)
//   expired - this is the TIMEOUT-th waiting cycle; transaction must end
module memory_arbiter_ack_watchdog
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

  // Number of waiting cycles already completed in this transaction.
  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign expired = enable && (cnt_q == CntWidth'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Memory arbiter: shares one single-port RAM between the instruction fetch
// stage and the memory (data) stage, with one RAM transaction outstanding at
// a time. Data requests win over fetches, except that the grant taken at the
// ack of a data transaction goes to a pending fetch so fetch cannot starve.
// A watchdog aborts transactions whose ack never arrives and sets a sticky
// timeout_err.
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   if_req, if_addr, flush          - fetch request, PC, discard in-flight fetch
//   if_ready, if_instruction        - fetch completion pulse and fetched word
//   if_freeze                       - fetch stage must hold PC
//   mem_rd_en, mem_wr_en            - data read/write request
//   mem_addr, mem_wr_data           - data address and write data
//   mem_ready, mem_rd_data          - data completion pulse and read data
//   mem_freeze                      - pipeline must stall for the data access
//   ram_req, ram_we                 - RAM request and write strobe
//   ram_addr, ram_wdata             - RAM address and write data
//   ram_rdata, ram_ack              - RAM read data and acknowledge
//   timeout_err                     - sticky ack-timeout flag
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  flush,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic                  if_freeze,

  input  logic                  mem_rd_en,
  input  logic                  mem_wr_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_freeze,

  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack,

  output logic                  timeout_err
);

  arb_state_e state_q;
  logic       flush_pending_q;

  logic busy;
  logic data_req;
  logic fetch_first;
  logic grant_data;
  logic grant_fetch;
  logic wd_expired;

  // The unused encoding counts as not busy so it falls into the grant path.
  assign busy     = (state_q == StFetch) || (state_q == StData);
  assign data_req = mem_rd_en | mem_wr_en;

  // Grants are only taken in IDLE or at ram_ack; in DATA that means the ack
  // of a data transaction, where a waiting fetch gets its turn.
  assign fetch_first = (state_q == StData) && if_req;
  assign grant_data  = data_req && !fetch_first;
  assign grant_fetch = if_req && !grant_data;

  memory_arbiter_ack_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy || ram_ack),
    .enable (busy && !ram_ack),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      flush_pending_q <= 1'b0;
      ram_req         <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      if_ready        <= 1'b0;
      if_instruction  <= '0;
      mem_ready       <= 1'b0;
      mem_rd_data     <= '0;
      timeout_err     <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;

      // Completion of the outstanding transaction.
      if (busy && ram_ack) begin
        if (state_q == StFetch) begin
          // A flush anywhere in the transaction, ack cycle included, drops the word.
          if (!(flush_pending_q || flush)) begin
            if_ready       <= 1'b1;
            if_instruction <= ram_rdata;
          end
        end else begin
          mem_ready <= 1'b1;
          if (!ram_we) begin
            mem_rd_data <= ram_rdata;
          end
        end
      end

      if (!busy || ram_ack) begin
        // Grant point: start the next transaction with no bubble, or go idle.
        flush_pending_q <= 1'b0;
        if (grant_data) begin
          state_q   <= StData;
          ram_req   <= 1'b1;
          ram_we    <= mem_wr_en;
          ram_addr  <= mem_addr;
          ram_wdata <= mem_wr_data;
        end else if (grant_fetch) begin
          state_q  <= StFetch;
          ram_req  <= 1'b1;
          ram_we   <= 1'b0;
          ram_addr <= if_addr;
        end else begin
          state_q <= StIdle;
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
        end
      end else if (wd_expired) begin
        // Abandon the transaction silently; the error flag stays set until reset.
        state_q         <= StIdle;
        ram_req         <= 1'b0;
        ram_we          <= 1'b0;
        flush_pending_q <= 1'b0;
        timeout_err     <= 1'b1;
      end else if ((state_q == StFetch) && flush) begin
        flush_pending_q <= 1'b1;
      end
    end
  end

  assign if_freeze  = if_req & ~if_ready;
  assign mem_freeze = data_req & ~mem_ready;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level reference
// model of the arbitration rules.
module tb_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 255;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          flush;
  logic          if_ready;
  logic [DW-1:0] if_instruction;
  logic          if_freeze;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_ready;
  logic [DW-1:0] mem_rd_data;
  logic          mem_freeze;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ack;
  logic          timeout_err;

  memory_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .flush         (flush),
    .if_ready      (if_ready),
    .if_instruction(if_instruction),
    .if_freeze     (if_freeze),
    .mem_rd_en     (mem_rd_en),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_ready     (mem_ready),
    .mem_rd_data   (mem_rd_data),
    .mem_freeze    (mem_freeze),
    .ram_req       (ram_req),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .ram_ack       (ram_ack),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), what the
  // outstanding request looks like, and what the stages have been told.
  int          m_owner;
  int          m_waited;
  bit          m_flushed;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_if_ready;
  logic [31:0] m_if_instr;
  logic        m_mem_ready;
  logic [31:0] m_rd_data;
  logic        m_err;
  bit          m_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    if (!m_valid) return;
    check_eq("ram_req", ram_req, (m_owner != 0));
    check_eq("ram_we", ram_we, m_we);
    if (m_owner != 0) check_eq("ram_addr", ram_addr, m_addr);
    if (m_owner == 2 && m_we) check_eq("ram_wdata", ram_wdata, m_wdata);
    check_eq("if_ready", if_ready, m_if_ready);
    check_eq("if_instruction", if_instruction, m_if_instr);
    check_eq("mem_ready", mem_ready, m_mem_ready);
    check_eq("mem_rd_data", mem_rd_data, m_rd_data);
    check_eq("timeout_err", timeout_err, m_err);
    check_eq("if_freeze", if_freeze, if_req && !m_if_ready);
    check_eq("mem_freeze", mem_freeze, (mem_rd_en || mem_wr_en) && !m_mem_ready);
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    int owner;
    owner       = m_owner;
    m_if_ready  = 1'b0;
    m_mem_ready = 1'b0;
    if (rst) begin
      m_owner    = 0;
      m_waited   = 0;
      m_flushed  = 1'b0;
      m_we       = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_if_instr = '0;
      m_rd_data  = '0;
      m_err      = 1'b0;
      m_valid    = 1'b1;
      return;
    end
    if (owner != 0 && ram_ack) begin
      if (owner == 1) begin
        if (!(m_flushed || flush)) begin
          m_if_ready = 1'b1;
          m_if_instr = ram_rdata;
        end
      end else begin
        m_mem_ready = 1'b1;
        if (!m_we) m_rd_data = ram_rdata;
      end
    end
    if (owner == 0 || ram_ack) begin
      if ((mem_rd_en || mem_wr_en) && !(owner == 2 && if_req)) begin
        m_owner = 2;
        m_addr  = mem_addr;
        m_we    = mem_wr_en;
        m_wdata = mem_wr_data;
      end else if (if_req) begin
        m_owner = 1;
        m_addr  = if_addr;
        m_we    = 1'b0;
      end else begin
        m_owner = 0;
        m_we    = 1'b0;
      end
      m_waited  = 0;
      m_flushed = 1'b0;
    end else if (m_waited + 1 == int'(TO)) begin
      m_err     = 1'b1;
      m_owner   = 0;
      m_we      = 1'b0;
      m_waited  = 0;
      m_flushed = 1'b0;
    end else begin
      m_waited++;
      if (owner == 1 && flush) m_flushed = 1'b1;
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst         = 1'b0;
    if_req      = 1'b0;
    if_addr     = '0;
    flush       = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    ram_ack     = 1'b0;
    ram_rdata   = '0;
  endtask

  task automatic drain();
    clear_inputs();
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic random_inputs();
    int r;
    rst         = ($urandom_range(0, 199) == 0);
    if_req      = ($urandom_range(0, 9) < 7);
    if_addr     = $urandom;
    flush       = ($urandom_range(0, 9) == 0);
    r           = $urandom_range(0, 9);
    mem_rd_en   = (r < 2) || (r == 9);
    mem_wr_en   = (r >= 2 && r < 4) || (r == 9);
    mem_addr    = $urandom;
    mem_wr_data = $urandom;
    ram_ack     = ($urandom_range(0, 9) < 4);
    ram_rdata   = $urandom;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_ram_req", ram_req, 1'b0);
    check_eq("rst_timeout_err", timeout_err, 1'b0);
    check_eq("rst_if_instruction", if_instruction, 32'h0);
    check_eq("rst_mem_rd_data", mem_rd_data, 32'h0);

    // Single fetch, ack on the second request cycle.
    if_req  = 1'b1;
    if_addr = 32'h10;
    tick();
    check_eq("f_ram_req", ram_req, 1'b1);
    check_eq("f_ram_addr", ram_addr, 32'h10);
    check_eq("f_freeze", if_freeze, 1'b1);
    tick();
    check_eq("f_freeze_wait", if_freeze, 1'b1);
    check_eq("f_no_ready", if_ready, 1'b0);
    ram_ack   = 1'b1;
    ram_rdata = 32'hE3A01005;
    tick();
    check_eq("f_ready", if_ready, 1'b1);
    check_eq("f_instr", if_instruction, 32'hE3A01005);
    check_eq("f_freeze_done", if_freeze, 1'b0);
    drain();

    // Data beats fetch, then fetch granted back-to-back at the data ack.
    mem_rd_en = 1'b1;
    mem_addr  = 32'h200;
    if_req    = 1'b1;
    if_addr   = 32'h20;
    tick();
    check_eq("p_data_first_addr", ram_addr, 32'h200);
    check_eq("p_data_first_we", ram_we, 1'b0);
    ram_ack   = 1'b1;
    ram_rdata = 32'h12345678;
    tick();
    check_eq("p_no_bubble", ram_req, 1'b1);
    check_eq("p_fetch_addr", ram_addr, 32'h20);
    check_eq("p_mem_ready", mem_ready, 1'b1);
    check_eq("p_rd_data", mem_rd_data, 32'h12345678);
    drain();

    // Write leaves mem_rd_data untouched.
    mem_wr_en   = 1'b1;
    mem_addr    = 32'h100;
    mem_wr_data = 32'hDEADBEEF;
    tick();
    check_eq("w_we", ram_we, 1'b1);
    check_eq("w_wdata", ram_wdata, 32'hDEADBEEF);
    check_eq("w_addr", ram_addr, 32'h100);
    clear_inputs();
    ram_ack   = 1'b1;
    ram_rdata = 32'h0BADF00D;
    tick();
    check_eq("w_ready", mem_ready, 1'b1);
    check_eq("w_rd_data_kept", mem_rd_data, 32'h12345678);
    drain();

    // Flush mid-fetch drops the word; the next fetch works.
    if_req  = 1'b1;
    if_addr = 32'h30;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    if_req    = 1'b0;
    ram_ack   = 1'b1;
    ram_rdata = 32'h11111111;
    tick();
    check_eq("fl_dropped", if_ready, 1'b0);
    ram_ack = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h34;
    tick();
    check_eq("fl_next_addr", ram_addr, 32'h34);
    if_req    = 1'b0;
    ram_ack   = 1'b1;
    ram_rdata = 32'hCAFE0001;
    tick();
    check_eq("fl_next_ready", if_ready, 1'b1);
    check_eq("fl_next_instr", if_instruction, 32'hCAFE0001);
    drain();

    // Watchdog: no ack for TO cycles.
    if_req  = 1'b1;
    if_addr = 32'h40;
    tick();
    if_req = 1'b0;
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    check_eq("to_not_yet", timeout_err, 1'b0);
    check_eq("to_still_req", ram_req, 1'b1);
    tick();
    check_eq("to_err", timeout_err, 1'b1);
    check_eq("to_idle", ram_req, 1'b0);
    check_eq("to_no_ready", if_ready, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("to_sticky", timeout_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("to_cleared", timeout_err, 1'b0);

    // Reset during a data transaction.
    mem_rd_en = 1'b1;
    mem_addr  = 32'h300;
    tick();
    check_eq("r_busy", ram_req, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("r_req_low", ram_req, 1'b0);
    check_eq("r_rd_data", mem_rd_data, 32'h0);
    check_eq("r_ram_addr", ram_addr, 32'h0);
    clear_inputs();
    ram_ack = 1'b1;
    tick();
    check_eq("r_no_ready", mem_ready, 1'b0);
    check_eq("r_no_if_ready", if_ready, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
